// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline definitions: memory-handshake FSM encoding, counter widths
// and the default memory-timeout length.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } ctrlStateT;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int WAIT_CNT_W             = 8;
    localparam int STALL_CNT_W            = 16;
    localparam int REG_ADDR_W             = 5;

    // Register 0 is hard-wired to zero, so it never carries a real dependency.
    function automatic logic regDepends(input logic [REG_ADDR_W-1:0] dst,
                                        input logic [REG_ADDR_W-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard detection: the ID-stage instruction reads the register
// that the load currently in EX has not yet produced.
module hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic                  idexMemRead,
    input  logic [REG_ADDR_W-1:0] idexRt,
    input  logic [REG_ADDR_W-1:0] ifidRs,
    input  logic [REG_ADDR_W-1:0] ifidRt,
    output logic                  loadUse
);

    assign loadUse = idexMemRead &&
                     (regDepends(idexRt, ifidRs) || regDepends(idexRt, ifidRt));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: sequences data-memory accesses through an
// IDLE/BUSY/DONE handshake and merges memory and load-use stalls.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ack_i,
    input  logic                   IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0]  IDEX_Rt_i,
    input  logic [REG_ADDR_W-1:0]  IFID_Rs_i,
    input  logic [REG_ADDR_W-1:0]  IFID_Rt_i,
    output logic                   mem_start_o,
    output logic                   pc_stall_o,
    output logic                   ifid_stall_o,
    output logic                   idex_stall_o,
    output logic                   exmem_stall_o,
    output logic                   memwb_stall_o,
    output logic                   idex_flush_o,
    output logic                   err_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    ctrlStateT              state;
    logic [WAIT_CNT_W-1:0]  waitCnt;
    logic [STALL_CNT_W-1:0] stallCnt;
    logic                   memStall;
    logic                   loadUse;

    hazard_detect hazardDetect (
        .idexMemRead (IDEX_MemRead_i),
        .idexRt      (IDEX_Rt_i),
        .ifidRs      (IFID_Rs_i),
        .ifidRt      (IFID_Rt_i),
        .loadUse     (loadUse)
    );

    // An ack arriving on the very last wait cycle still counts as success.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            waitCnt <= '0;
            err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_i) begin
                        state   <= BUSY;
                        waitCnt <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        state   <= DONE;
                        waitCnt <= '0;
                    end else if (waitCnt == WAIT_LAST) begin
                        state   <= DONE;
                        waitCnt <= '0;
                        err_o   <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stallCnt <= '0;
        end else if (memwb_stall_o && (stallCnt != '1)) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign stall_cnt_o = stallCnt;
    assign memStall    = ((state == IDLE) && mem_req_i) || (state == BUSY);
    assign mem_start_o = (state == IDLE) && mem_req_i;

    // A memory stall freezes the whole pipe, so it overrides the load-use bubble.
    always_comb begin
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        idex_stall_o  = 1'b0;
        exmem_stall_o = 1'b0;
        memwb_stall_o = 1'b0;
        idex_flush_o  = 1'b0;
        if (memStall) begin
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_stall_o  = 1'b1;
            exmem_stall_o = 1'b1;
            memwb_stall_o = 1'b1;
        end else if (loadUse) begin
            pc_stall_o   = 1'b1;
            ifid_stall_o = 1'b1;
            idex_flush_o = 1'b1;
        end
    end

endmodule
